// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-stage responder. Accepts the ALU memory-operation record, performs
//   loads/stores on a local word-organised data RAM and produces the register
//   write-back record. Non-memory ALU write-backs are forwarded with the same
//   one-cycle latency so write-back order equals issue order.
//
// Ports
//   clk        core clock, rising edge
//   rst        synchronous active-high reset
//   memOpIn    {read, write, addr[31:0], data[31:0], opType[2:0], rdAddr[4:0]}
//   regOpIn    {dv, addr[4:0], data[31:0]} from the ALU
//   regOpOut   {dv, addr[4:0], data[31:0]} to the register file
//   stall      high while the second half of a split access is in progress
//   accessErr  one-cycle pulse (cycle after accept) on an illegal access
//
// Build option
//   MEM_MISALIGN_SPLIT_EN  defined: misaligned accesses are split over two RAM
//                          words via an IDLE/SPLIT FSM.
//                          undefined: misaligned accesses raise accessErr and
//                          perform no access; stall is tied low.
module mem_access_stage #(
  parameter int unsigned pRamDepth = 1024,
  parameter int unsigned pXlen     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*pXlen+9:0]   memOpIn,
  input  logic [pXlen+5:0]     regOpIn,
  output logic [pXlen+5:0]     regOpOut,
  output logic                 stall,
  output logic                 accessErr
);

  localparam int unsigned cAW = $clog2(pRamDepth);

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  opType;
    logic [4:0]  rdAddr;
  } mem_op_t;

  typedef struct packed {
    logic        dv;
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_op_t;

  mem_op_t         w_mop;
  reg_op_t         w_rin;
  logic [cAW-1:0]  w_idx;
  logic [1:0]      w_off;
  logic            w_req;
  logic            w_size_ok;
  logic            w_illegal;
  logic            w_misal;
  logic            w_misal_ok;
  logic            w_busy;
  logic            w_acc;
  logic            w_err_now;
  logic [7:0]      w_szmask;
  logic [7:0]      w_be64;
  logic [63:0]     w_wd64;
  logic [63:0]     w_dw;
  logic [31:0]     w_ld_data;
  logic            w_unused_bits;

  logic [31:0]     r_mem [pRamDepth];
  logic [31:0]     r_rdLo;
  logic [31:0]     r_rdHi;
  logic [cAW-1:0]  r_hiIdx;
  logic [3:0]      r_hiBe;
  logic [31:0]     r_hiData;
  logic            r_isLoad;
  logic            r_ldValid;
  logic [2:0]      r_ldType;
  logic [1:0]      r_ldOff;
  logic [4:0]      r_ldRd;
  reg_op_t         r_pass;
  logic            r_err;

  assign w_mop = memOpIn;
  assign w_rin = regOpIn;
  assign w_idx = w_mop.addr[cAW+1:2];
  assign w_off = w_mop.addr[1:0];
  assign w_unused_bits = ^w_mop.addr[31:cAW+2];

  // Decode: legal sizes and misalignment
  assign w_req     = w_mop.read | w_mop.write;
  assign w_size_ok = (w_mop.opType == 3'b000) || (w_mop.opType == 3'b001) ||
                     (w_mop.opType == 3'b010) || (w_mop.opType == 3'b100) ||
                     (w_mop.opType == 3'b101);
  assign w_illegal = (w_mop.read & w_mop.write) | ~w_size_ok;
  assign w_misal   = ((w_mop.opType[1:0] == 2'b01) && (w_off == 2'b11)) ||
                     ((w_mop.opType[1:0] == 2'b10) && (w_off != 2'b00));

  assign w_acc     = ~w_busy & w_req & ~w_illegal & (~w_misal | w_misal_ok);
  assign w_err_now = ~w_busy & w_req & (w_illegal | (w_misal & ~w_misal_ok));

`ifdef MEM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t r_state;
  state_t w_state_nx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_acc && w_misal) w_state_nx = SPLIT;
      SPLIT:   w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_busy     = (r_state == SPLIT);
  assign w_misal_ok = 1'b1;
`else
  assign w_busy     = 1'b0;
  assign w_misal_ok = 1'b0;
`endif

  assign stall     = w_busy;
  assign accessErr = r_err;

  // Lanes and data are laid out over a two-word (64-bit) window starting at
  // word N; the upper half is only non-zero for a split access.
  always_comb begin
    w_szmask = 8'h0F;
    case (w_mop.opType[1:0])
      2'b00:   w_szmask = 8'h01;
      2'b01:   w_szmask = 8'h03;
      default: w_szmask = 8'h0F;
    endcase
  end

  assign w_be64 = w_szmask << w_off;
  assign w_wd64 = {32'h0, w_mop.data} << {w_off, 3'b000};

  // RAM: not reset; writes and reads are suppressed while rst is asserted so a
  // reset in SPLIT leaves only the first-cycle lanes written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_acc && w_mop.write) begin
        for (int unsigned b = 0; b < 4; b++)
          if (w_be64[b]) r_mem[w_idx][8*b +: 8] <= w_wd64[8*b +: 8];
      end
      if (w_busy && !r_isLoad) begin
        for (int unsigned c = 0; c < 4; c++)
          if (r_hiBe[c]) r_mem[r_hiIdx][8*c +: 8] <= r_hiData[8*c +: 8];
      end
      if (w_acc && w_mop.read) r_rdLo <= r_mem[w_idx];
      if (w_busy && r_isLoad)  r_rdHi <= r_mem[r_hiIdx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ldValid <= 1'b0;
      r_err     <= 1'b0;
      r_pass    <= '0;
      r_isLoad  <= 1'b0;
      r_hiIdx   <= '0;
      r_hiBe    <= '0;
      r_hiData  <= '0;
      r_ldType  <= '0;
      r_ldOff   <= '0;
      r_ldRd    <= '0;
    end else begin
      r_ldValid   <= (w_acc & w_mop.read & ~w_misal) | (w_busy & r_isLoad);
      r_err       <= w_err_now;
      // A load accepted in the same cycle wins over the pass-through record.
      r_pass.dv   <= w_rin.dv & (w_rin.addr != 5'd0) & ~w_busy & ~(w_acc & w_mop.read);
      r_pass.addr <= w_rin.addr;
      r_pass.data <= w_rin.data;
      if (w_acc) begin
        r_hiIdx  <= w_idx + 1'b1;
        r_hiBe   <= w_be64[7:4];
        r_hiData <= w_wd64[63:32];
        r_isLoad <= w_mop.read;
        if (w_mop.read) begin
          r_ldType <= w_mop.opType;
          r_ldOff  <= w_off;
          r_ldRd   <= w_mop.rdAddr;
        end
      end
    end
  end

  // Little-endian merge of word N (low) and N+1 (high), then size/extend.
  assign w_dw = {r_rdHi, r_rdLo} >> {r_ldOff, 3'b000};

  always_comb begin
    w_ld_data = w_dw[31:0];
    case (r_ldType)
      3'b000:  w_ld_data = {{24{w_dw[7]}}, w_dw[7:0]};
      3'b001:  w_ld_data = {{16{w_dw[15]}}, w_dw[15:0]};
      3'b100:  w_ld_data = {24'h0, w_dw[7:0]};
      3'b101:  w_ld_data = {16'h0, w_dw[15:0]};
      default: w_ld_data = w_dw[31:0];
    endcase
  end

  always_comb begin
    regOpOut = r_pass;
    if (r_ldValid) regOpOut = {(r_ldRd != 5'd0), r_ldRd, w_ld_data};
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic [73:0] memOpIn;
  logic [37:0] regOpIn;
  logic [37:0] regOpOut;
  logic        stall;
  logic        accessErr;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_access_stage #(.pRamDepth(1024), .pXlen(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .memOpIn   (memOpIn),
    .regOpIn   (regOpIn),
    .regOpOut  (regOpOut),
    .stall     (stall),
    .accessErr (accessErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream never issues a load together with a valid ALU write-back.
  always @(posedge clk) begin
    if (!rst) assert (!(memOpIn[73] && regOpIn[37]));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] rop(input logic dv, input logic [4:0] a, input logic [31:0] d);
    return {dv, a, d};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] op, input logic [4:0] rda);
    memOpIn = {rd, wr, a, d, op, rda};
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    set_mem(1'b0, 1'b1, a, d, op, 5'd0);
    step;
    memOpIn = '0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [2:0] op,
                          input logic [4:0] rda, input logic [37:0] exp);
    set_mem(1'b1, 1'b0, a, 32'h0, op, rda);
    step;
    chk(tag, regOpOut, exp);
    memOpIn = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    memOpIn  = '0;
    regOpIn  = '0;
    repeat (2) step;
    chk("rst_regOpOut", regOpOut, 38'h0);
    chk("rst_stall", stall, 0);
    chk("rst_err", accessErr, 0);
    rst = 1'b0;
    step;

    // Aligned word store / load
    store(32'h10, 32'hDEADBEEF, 3'b010);
    chk("sw_noerr", accessErr, 0);
    load_chk("lw_x5", 32'h10, 3'b010, 5'd5, rop(1'b1, 5'd5, 32'hDEADBEEF));

    // Byte store and sign/zero-extended sub-word loads
    store(32'h13, 32'h00000080, 3'b000);
    load_chk("lb_x6", 32'h13, 3'b000, 5'd6, rop(1'b1, 5'd6, 32'hFFFFFF80));
    load_chk("lbu_x6", 32'h13, 3'b100, 5'd6, rop(1'b1, 5'd6, 32'h00000080));
    load_chk("lw_merge", 32'h10, 3'b010, 5'd9, rop(1'b1, 5'd9, 32'h80ADBEEF));
    load_chk("lh_hi", 32'h12, 3'b001, 5'd10, rop(1'b1, 5'd10, 32'hFFFF80AD));
    load_chk("lhu_hi", 32'h12, 3'b101, 5'd10, rop(1'b1, 5'd10, 32'h000080AD));
    load_chk("lw_x0", 32'h10, 3'b010, 5'd0, rop(1'b0, 5'd0, 32'h80ADBEEF));
    load_chk("lw_wrap_addr", 32'h1010, 3'b010, 5'd3, rop(1'b1, 5'd3, 32'h80ADBEEF));

    // Pass-through
    regOpIn = rop(1'b1, 5'd7, 32'h1234);
    step;
    chk("pass_x7", regOpOut, rop(1'b1, 5'd7, 32'h1234));
    regOpIn = rop(1'b1, 5'd0, 32'h55);
    step;
    chk("pass_x0", regOpOut, rop(1'b0, 5'd0, 32'h55));
    regOpIn = '0;

    // Illegal opType and read+write
    set_mem(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 5'd4);
    step;
    chk("badop_err", accessErr, 1);
    chk("badop_nodv", regOpOut[37], 0);
    memOpIn = '0;
    step;
    chk("badop_pulse", accessErr, 0);
    set_mem(1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 5'd4);
    step;
    chk("rw_err", accessErr, 1);
    chk("rw_nodv", regOpOut[37], 0);
    memOpIn = '0;
    step;
    load_chk("rw_nowrite", 32'h10, 3'b010, 5'd9, rop(1'b1, 5'd9, 32'h80ADBEEF));

    store(32'h20, 32'h11111111, 3'b010);
    store(32'h24, 32'h22222222, 3'b010);
    store(32'hFFC, 32'h44443333, 3'b010);
    store(32'h0, 32'h66665555, 3'b010);

`ifdef MEM_MISALIGN_SPLIT_EN
    // Split store at 0x21 (upstream holds inputs while stalled)
    set_mem(1'b0, 1'b1, 32'h21, 32'hAABBCCDD, 3'b010, 5'd0);
    step;
    chk("ssw_stall1", stall, 1);
    step;
    chk("ssw_stall0", stall, 0);
    chk("ssw_noerr", accessErr, 0);
    memOpIn = '0;
    load_chk("ssw_w20", 32'h20, 3'b010, 5'd1, rop(1'b1, 5'd1, 32'hBBCCDD11));
    load_chk("ssw_w24", 32'h24, 3'b010, 5'd1, rop(1'b1, 5'd1, 32'h222222AA));

    // Split load at 0x21
    set_mem(1'b1, 1'b0, 32'h21, 32'h0, 3'b010, 5'd8);
    step;
    chk("slw_stall1", stall, 1);
    chk("slw_nodv1", regOpOut[37], 0);
    step;
    chk("slw_stall0", stall, 0);
    chk("slw_x8", regOpOut, rop(1'b1, 5'd8, 32'hAABBCCDD));
    memOpIn = '0;

    // Wrap-around split load: word 1023 then word 0
    set_mem(1'b1, 1'b0, 32'hFFE, 32'h0, 3'b010, 5'd11);
    step;
    step;
    chk("wrap_x11", regOpOut, rop(1'b1, 5'd11, 32'h55554444));
    memOpIn = '0;

    // Reset during SPLIT
    set_mem(1'b1, 1'b0, 32'h21, 32'h0, 3'b010, 5'd12);
    step;
    chk("rsplit_stall1", stall, 1);
    rst     = 1'b1;
    memOpIn = '0;
    step;
    chk("rsplit_stall0", stall, 0);
    chk("rsplit_out", regOpOut, 38'h0);
    rst = 1'b0;
    step;
`else
    // Misaligned store: error, RAM untouched
    set_mem(1'b0, 1'b1, 32'h21, 32'hAABBCCDD, 3'b010, 5'd0);
    step;
    chk("msw_err", accessErr, 1);
    chk("msw_stall", stall, 0);
    memOpIn = '0;
    step;
    chk("msw_pulse", accessErr, 0);
    load_chk("msw_w20", 32'h20, 3'b010, 5'd1, rop(1'b1, 5'd1, 32'h11111111));
    load_chk("msw_w24", 32'h24, 3'b010, 5'd1, rop(1'b1, 5'd1, 32'h22222222));

    // Misaligned loads: error, no write-back
    set_mem(1'b1, 1'b0, 32'h21, 32'h0, 3'b010, 5'd8);
    step;
    chk("mlw_err", accessErr, 1);
    chk("mlw_nodv", regOpOut[37], 0);
    set_mem(1'b1, 1'b0, 32'h23, 32'h0, 3'b001, 5'd8);
    step;
    chk("mlh_err", accessErr, 1);
    chk("mlh_nodv", regOpOut[37], 0);
    set_mem(1'b1, 1'b0, 32'hFFE, 32'h0, 3'b010, 5'd11);
    step;
    chk("mwrap_err", accessErr, 1);
    chk("mwrap_stall", stall, 0);
    memOpIn = '0;
    step;
    // Aligned half at offset 2 of word 0x20 is still legal
    load_chk("lh_legal", 32'h22, 3'b101, 5'd2, rop(1'b1, 5'd2, 32'h00001111));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage responder: consumes the ALU's memory-operation record (tMemOp) and performs loads and stores on a local word-organised data RAM.
- Produces the register write-back record (tRegOp) for loads.
- Forwards ALU register write-backs with matched latency, so write-back order equals issue order.
- Sits between the ALU output (tAluOut.memOp / tAluOut.regOp) and the register file write port.

Parameters:
- pRamDepth, cRamDepth (1024): number of 32-bit words in the data RAM; must be a power of 2.
- pXlen, cXLEN (32): data/address width; only 32 is supported.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- memOpIn  in  74  tMemOp from the ALU. Fields: read, write, addr[31:0], data[31:0], opType[2:0] (RISC-V funct3), rdAddr[4:0].
- regOpIn  in  38  tRegOp from the ALU (non-memory write-back).
- regOpOut  out  38  tRegOp to the register file.
- stall  out  1  high while a split access is in progress; upstream holds its inputs.
- accessErr  out  1  one-cycle pulse on an illegal access.

Behaviour:
- Reset: regOpOut = 0 (dv=0, addr=0, data=0); stall=0; accessErr=0; FSM=IDLE. RAM contents are not reset.
- Word index = addr[log2(pRamDepth)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*pRamDepth bytes.
- opType decode:
  - 000 = byte, 001 = half, 010 = word, 100 = byte unsigned, 101 = half unsigned.
  - Other codes: illegal, so accessErr=1 and no access.
- read=1 and write=1 together: illegal, so accessErr=1, no access, no write-back.
- Store, aligned:
  - Byte enables are derived from size and addr[1:0].
  - data[7:0] or data[15:0] is replicated into the selected lanes.
  - The RAM is written at the end of the accept cycle.
  - No write-back.
- Load, aligned:
  - Synchronous RAM read; regOpOut is valid on the next cycle (latency 1).
  - Byte/half is extracted by addr[1:0], then sign-extended (000, 001) or zero-extended (100, 101).
  - regOpOut.addr = rdAddr.
  - regOpOut.dv = 1 unless rdAddr == 0.
- Pass-through: regOpIn is registered to regOpOut (latency 1), with dv forced to 0 when addr == 0.
- Collision: if a load and regOpIn.dv=1 arrive in the same cycle, the load wins and regOpIn is dropped. Upstream guarantees exclusivity; the bench asserts it never occurs.
- Misaligned access: a half at addr[1:0]=11, or a word at addr[1:0]≠00. Handling is per the Optional Feature below.
- FSM (split mode): IDLE -> SPLIT -> IDLE.
  - IDLE: accepts an op. If misaligned, it accesses word N, latches the op, and goes to SPLIT.
  - SPLIT: stall=1 and all inputs are ignored. It accesses word N+1 (wraps pRamDepth-1 -> 0) and returns to IDLE.
  - Split load: regOpOut is valid one cycle after SPLIT (latency 2 from accept), with both halves merged little-endian.
  - Split store: low lanes are written in IDLE, high lanes in SPLIT.
- A memOp with read=0 and write=0 performs no RAM access.
- Reset during SPLIT: FSM -> IDLE, no write-back is produced, stall drops the next cycle. Lanes already written in the first cycle stay written.

Optional Feature:
- Macro: MEM_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses use the IDLE/SPLIT FSM above; accessErr is not raised for misalignment.
- Undefined: no SPLIT state and stall is tied to 0. A misaligned access pulses accessErr for one cycle, suppresses the store entirely, and produces no load write-back (regOpOut.dv=0).

Test Plan:
- Store word 0xDEADBEEF at 0x10, then LW x5 at 0x10 -> next cycle regOpOut = {dv=1, addr=5, data=0xDEADBEEF}.
- SB 0x80 at 0x13, then LB x6 at 0x13 -> 0xFFFFFF80. LBU x6 at 0x13 -> 0x00000080. Word 0x10 reads back 0x80ADBEEF.
- regOpIn {dv=1, addr=7, data=0x1234} -> regOpOut matches one cycle later. regOpIn with addr=0 -> regOpOut.dv=0.
- Split enabled: SW 0xAABBCCDD at 0x21, then LW x8 at 0x21.
  - Each access raises stall for exactly 1 cycle.
  - The load returns 0xAABBCCDD two cycles after accept.
  - Bytes land at 0x21..0x24.
- Split disabled: SW at 0x21 -> accessErr pulses once and the RAM is unchanged. LW at 0x21 -> no dv.
- read=write=1 -> accessErr pulses. Also: wrap-around split LW at 4*pRamDepth-2 reads words pRamDepth-1 then 0. Also: rst asserted during SPLIT -> stall=0 and dv=0 the next cycle.
